// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: single register-file write port shared by the WB stage and a FIFO-buffered long-latency unit
module regfile_wb_arbiter #(
  parameter int DEPTH = 4,
  parameter int AW = 5,
  parameter int DW = 32,
  localparam int PW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          pipe_wr_en,
  input  logic [AW-1:0] pipe_wr_addr,
  input  logic [DW-1:0] pipe_wr_data,
  input  logic          lu_valid,
  output logic          lu_ready,
  input  logic [AW-1:0] lu_addr,
  input  logic [DW-1:0] lu_data,
  output logic          WriteReg,
  output logic [AW-1:0] WrAddr,
  output logic [DW-1:0] WrData,
  input  logic [AW-1:0] RdAddr1,
  input  logic [AW-1:0] RdAddr2,
  output logic          pend1,
  output logic          pend2,
  output logic [PW:0]   q_count
);
  logic [AW-1:0] q_addr [DEPTH];
  logic [DW-1:0] q_data [DEPTH];
  logic [DEPTH-1:0] q_live, kill;
  logic [PW-1:0] head, tail;
  logic pipe_req, head_live, pop, enq, enq_live;
  assign pipe_req = pipe_wr_en && pipe_wr_addr != '0;
  assign head_live = q_live[head];
  assign pop = q_count != '0 && !(pipe_req && head_live);
  assign lu_ready = !reset && q_count != (PW+1)'(DEPTH);
  assign enq = lu_valid && lu_ready && lu_addr != '0;
  assign enq_live = !(pipe_req && lu_addr == pipe_wr_addr);
  always_comb begin
    kill = '0;
    pend1 = 1'b0;
    pend2 = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      kill[i] = pipe_req && q_addr[i] == pipe_wr_addr;
      pend1 = pend1 | (q_live[i] && RdAddr1 != '0 && q_addr[i] == RdAddr1);
      pend2 = pend2 | (q_live[i] && RdAddr2 != '0 && q_addr[i] == RdAddr2);
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      WriteReg <= 1'b0;
      WrAddr <= '0;
      WrData <= '0;
      q_count <= '0;
      q_live <= '0;
      head <= '0;
      tail <= '0;
    end else begin
      WriteReg <= pipe_req || head_live;
      if (pipe_req) begin
        WrAddr <= pipe_wr_addr;
        WrData <= pipe_wr_data;
      end else if (head_live) begin
        WrAddr <= q_addr[head];
        WrData <= q_data[head];
      end
      for (int i = 0; i < DEPTH; i++)
        if (kill[i] || (pop && head == PW'(i))) q_live[i] <= 1'b0;
      if (enq) begin
        q_live[tail] <= enq_live;
        tail <= tail + 1'b1;
      end
      head <= head + PW'(pop);
      q_count <= q_count + (PW+1)'(enq) - (PW+1)'(pop);
    end
  end
  always_ff @(posedge clk)
    if (enq) begin
      q_addr[tail] <= lu_addr;
      q_data[tail] <= lu_data;
    end
endmodule
